camera_input_bank: RTL

Parametrised multi-channel camera input capture block with an Avalon-MM slave for the Nios II system. It replaces a bank of fixed 15-bit input PIOs with a single slave that does four things:
- synchronises NUM_CH parallel camera words;
- applies a per-channel stability filter;
- keeps live or frozen (atomic snapshot) data registers;
- flags per-channel value changes through a maskable interrupt.

---
 rtl/camera_input_bank.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/camera_input_bank.sv
// camera_input_bank: multi-channel camera word capture with an Avalon-MM slave.
// Each channel is synchronised, passed through a stability filter, then held in
// a data register that either tracks the filter (live) or is updated only by an
// atomic snapshot (frozen). Accepted changes latch into a W1C status register
// whose masked OR drives a registered, level-sensitive interrupt.
module camera_input_bank #(
    parameter int NUM_CH      = 10,
    parameter int DATA_W      = 15,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 4
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic [NUM_CH*DATA_W-1:0] camera_input_export,
    input  logic [5:0]               avs_address,
    input  logic                     avs_read,
    input  logic                     avs_write,
    input  logic [31:0]              avs_writedata,
    output logic [31:0]              avs_readdata,
    output logic                     irq
);

    if (NUM_CH < 1 || NUM_CH > 32 || DATA_W < 1 || DATA_W > 32 ||
        SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYC < 1 || STABLE_CYC > 255) begin : g_bad_param
        $error("camera_input_bank: parameter out of range");
    end

    // The counter holds (identical samples seen - 1), so it reaches CNT_MAX on
    // the cycle in which sync_q has been steady for STABLE_CYC samples.
    localparam logic [7:0] CNT_MAX     = 8'(STABLE_CYC - 1);
    localparam logic [5:0] ADDR_CTRL   = 6'(NUM_CH);
    localparam logic [5:0] ADDR_STATUS = 6'(NUM_CH + 1);
    localparam logic [5:0] ADDR_MASK   = 6'(NUM_CH + 2);

    logic [NUM_CH-1:0] acc_s;
    logic [DATA_W-1:0] dreg_s [NUM_CH];
    logic              freeze_r;
    logic [NUM_CH-1:0] status_r;
    logic [NUM_CH-1:0] mask_r;
    logic [NUM_CH-1:0] w1c_s;
    logic              wr_ctrl_s;
    logic              wr_status_s;
    logic              wr_mask_s;
    logic              snap_s;
    logic [DATA_W-1:0] data_rd_s;
    logic [31:0]       rd_s;
    logic              unused_wdata_s;

    assign unused_wdata_s = ^avs_writedata;

    assign wr_ctrl_s   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_status_s = avs_write && (avs_address == ADDR_STATUS);
    assign wr_mask_s   = avs_write && (avs_address == ADDR_MASK);
    // A snapshot only happens if the same write leaves the block frozen.
    assign snap_s      = wr_ctrl_s && avs_writedata[1] && avs_writedata[0];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [DATA_W-1:0] sync_r [SYNC_STAGES];
        logic [7:0]        cnt_r;
        logic [DATA_W-1:0] filt_r;
        logic [DATA_W-1:0] dreg_r;
        logic [DATA_W-1:0] sync_q_s;
        logic [DATA_W-1:0] sync_d_s;

        assign sync_q_s  = sync_r[SYNC_STAGES-1];
        assign sync_d_s  = sync_r[SYNC_STAGES-2];
        assign acc_s[ch] = (cnt_r == CNT_MAX) && (sync_q_s != filt_r);
        assign dreg_s[ch] = dreg_r;

        // Synchroniser chain bringing the asynchronous camera word into clk_clk.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
            end else begin
                sync_r[0] <= camera_input_export[ch*DATA_W +: DATA_W];
                for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
            end
        end

        // Stability counter: cleared on the edge where sync_q takes a new value
        // (looked ahead from the previous stage), else counts up and saturates.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                cnt_r <= 8'd0;
            end else if (sync_d_s != sync_q_s) begin
                cnt_r <= 8'd0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end

        // Filtered value: accepts sync_q once it has been steady long enough.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                filt_r <= '0;
            end else if (acc_s[ch]) begin
                filt_r <= sync_q_s;
            end else begin
                filt_r <= filt_r;
            end
        end

        // Data register: snapshot takes the pre-update filter value; otherwise
        // it tracks filter updates only while live.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                dreg_r <= '0;
            end else if (snap_s) begin
                dreg_r <= filt_r;
            end else if (!freeze_r && acc_s[ch]) begin
                dreg_r <= sync_q_s;
            end else begin
                dreg_r <= dreg_r;
            end
        end
    end

    // W1C mask for the status register, only on a STATUS write.
    always_comb begin
        w1c_s = '0;
        if (wr_status_s) begin
            w1c_s = avs_writedata[NUM_CH-1:0];
        end else begin
            w1c_s = '0;
        end
    end

    // Control, status and mask registers; a new acceptance beats a clear.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            freeze_r <= 1'b0;
            status_r <= '0;
            mask_r   <= '0;
        end else begin
            freeze_r <= wr_ctrl_s ? avs_writedata[0] : freeze_r;
            mask_r   <= wr_mask_s ? avs_writedata[NUM_CH-1:0] : mask_r;
            status_r <= (status_r & ~w1c_s) | acc_s;
        end
    end

    // Registered interrupt from masked status.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status_r & mask_r);
        end
    end

    // Read multiplexer over current register state.
    always_comb begin
        data_rd_s = '0;
        rd_s      = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            data_rd_s = data_rd_s | ((avs_address == 6'(i)) ? dreg_s[i] : '0);
        end
        if (avs_address == ADDR_CTRL) begin
            rd_s[0] = freeze_r;
        end else if (avs_address == ADDR_STATUS) begin
            rd_s[NUM_CH-1:0] = status_r;
        end else if (avs_address == ADDR_MASK) begin
            rd_s[NUM_CH-1:0] = mask_r;
        end else begin
            rd_s[DATA_W-1:0] = data_rd_s;
        end
    end

    // Read data register: latency one, held until the next read.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata <= 32'd0;
        end else if (avs_read) begin
            avs_readdata <= rd_s;
        end else begin
            avs_readdata <= avs_readdata;
        end
    end

endmodule
